mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: default line size, FSM state
// encoding and the requester ID encoding.
package mem_bus_arbiter_pkg;

  // Words per cache line.
  localparam int unsigned LineWords = 4;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StGrantI   = 3'd1,
    StGrantDRd = 3'd2,
    StGrantDWr = 3'd3,
    StDone     = 3'd4
  } arb_state_e;

  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin arbiter between the ICache and DCache.
// On a tie the requester that was not granted last wins.
//   req_i_i      : ICache request
//   req_d_i      : DCache request
//   last_grant_i : requester served most recently
//   gnt_valid_o  : some request is present
//   gnt_o        : chosen requester (meaningful only with gnt_valid_o)
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic    req_i_i,
  input  logic    req_d_i,
  input  req_id_e last_grant_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_o
);

  always_comb begin
    gnt_valid_o = req_i_i | req_d_i;
    gnt_o       = ReqI;
    if (req_i_i && req_d_i) begin
      gnt_o = (last_grant_i == ReqI) ? ReqD : ReqI;
    end else if (req_d_i) begin
      gnt_o = ReqD;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single-port memory between an ICache (line reads) and a DCache
// (line reads or single-word stores). Line reads are split into LINE_WORDS
// word beats and assembled into a shared line buffer.
//   clk, rst                 : clock, asynchronous active-low reset
//   i_valid/i_addr           : ICache line-read request
//   i_ready/i_rdata          : ICache done pulse and assembled line
//   d_valid/d_for_store/...  : DCache request (store = one write beat)
//   d_ready/d_rdata          : DCache done pulse and assembled line
//   m_*                      : memory beat interface, m_ready completes a beat
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LineWords,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_ready,
  output logic [LINE_WORDS*DATA_W-1:0] i_rdata,
  input  logic                         d_valid,
  input  logic                         d_for_store,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  input  logic [3:0]                   d_wstrb,
  output logic                         d_ready,
  output logic [LINE_WORDS*DATA_W-1:0] d_rdata,
  output logic                         m_valid,
  output logic                         m_we,
  output logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [3:0]                   m_wstrb,
  input  logic                         m_ready,
  input  logic [DATA_W-1:0]            m_rdata
);

  localparam int unsigned CntW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LineW = LINE_WORDS * DATA_W;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(LINE_WORDS * 4 - 1);

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  req_id_e           last_grant_q, last_grant_d;
  req_id_e           gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [LineW-1:0]  line_q, line_d;

  logic    arb_valid;
  req_id_e arb_gnt;

  rr_arbiter2 u_rr_arbiter2 (
    .req_i_i     (i_valid),
    .req_d_i     (d_valid),
    .last_grant_i(last_grant_q),
    .gnt_valid_o (arb_valid),
    .gnt_o       (arb_gnt)
  );

  assign i_rdata = line_q;
  assign d_rdata = line_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    line_d       = line_q;
    m_valid      = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    m_wstrb      = '0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (arb_valid) begin
          gnt_d = arb_gnt;
          if (arb_gnt == ReqI) begin
            addr_d  = i_addr & AlignMask;
            wdata_d = '0;
            wstrb_d = '0;
            state_d = StGrantI;
          end else begin
            // d_for_store is captured by the choice of state.
            addr_d  = d_for_store ? d_addr : (d_addr & AlignMask);
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
            state_d = d_for_store ? StGrantDWr : StGrantDRd;
          end
        end
      end
      StGrantI, StGrantDRd: begin
        m_valid = 1'b1;
        m_addr  = addr_q + ADDR_W'({cnt_q, 2'b00});
        if (m_ready) begin
          line_d[int'(cnt_q)*DATA_W +: DATA_W] = m_rdata;
          if (cnt_q == CntW'(LINE_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StGrantDWr: begin
        m_valid = 1'b1;
        m_we    = 1'b1;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_wstrb = wstrb_q;
        if (m_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        i_ready      = (gnt_q == ReqI);
        d_ready      = (gnt_q == ReqD);
        last_grant_d = gnt_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= ReqI;
      gnt_q        <= ReqI;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      line_q       <= line_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of directed transactions,
// hand-written stall and reset sequences, then randomized traffic. Expected
// beat lists, service order and lines come from a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int LW = 4;
  localparam int LB = LW * 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0, d_valid = 1'b0, d_for_store = 1'b0;
  logic [31:0]   i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          i_ready, d_ready, m_valid, m_we;
  logic [LB-1:0] i_rdata, d_rdata;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic          m_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit dmode = 1'b0;   // 0: memory returns beat index, 1: address hash
  int rmode = 0;      // 0: m_ready always 1, 1: random, 2: stall beat 2
  int stall_cnt = 0;
  int model_last = 0; // 0 = I served last, 1 = D

  mem_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_addr     (i_addr),
    .i_ready    (i_ready),
    .i_rdata    (i_rdata),
    .d_valid    (d_valid),
    .d_for_store(d_for_store),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_ready    (d_ready),
    .d_rdata    (d_rdata),
    .m_valid    (m_valid),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (dmode) return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    return {30'd0, a[3:2]};
  endfunction

  assign m_rdata = dmode ? ((m_addr * 32'h9E37_79B1) ^ 32'h0BAD_F00D) : {30'd0, m_addr[3:2]};

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  typedef struct {
    bit            is_d;
    logic [LB-1:0] rdata;
    int            c;
  } rdy_t;

  beat_t beats[$];
  rdy_t  rdys[$];
  bit    prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  // Monitor: sampled mid-cycle, values hold until the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      check("idle beat fields zero", LB'({m_we, m_wdata, m_wstrb} & {37{!m_valid}}), '0);
      check("ready exclusive", LB'(i_ready & d_ready), '0);
      if (prev_stall) begin
        check("stalled beat held", LB'({m_valid, m_addr}), LB'({1'b1, prev_addr}));
      end
      prev_stall = m_valid && !m_ready;
      prev_addr  = m_addr;
      if (m_valid && m_ready) beats.push_back('{m_we, m_addr, m_wdata, m_wstrb});
      if (i_ready) rdys.push_back('{1'b0, i_rdata, cyc});
      if (d_ready) rdys.push_back('{1'b1, d_rdata, cyc});
    end
  end

  // Memory-side handshake driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) begin
        m_ready = ($urandom_range(0, 3) != 0);
      end else if (rmode == 2 && m_valid && m_addr[3:2] == 2'd2 && stall_cnt < 3) begin
        m_ready = 1'b0;
        stall_cnt++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // One arbitration episode: I issues at most one line read, D issues
  // d_count identical requests back to back; all valids raised together.
  task automatic do_txn(input string tag, input bit use_i, input bit use_d, input bit d_st,
                        input int d_count, input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] ws, input int exp_lat,
                        input int exp_first);
    bit            order[$];
    beat_t         eb[$];
    logic [LB-1:0] el[$];
    int ni, nd, pi, pd, last, start, waited, iseen, dseen;
    ni = use_i ? 1 : 0;
    nd = use_d ? d_count : 0;
    pi = ni;
    pd = nd;
    last = model_last;
    while (pi + pd > 0) begin
      bit pick;
      if (pi > 0 && pd > 0) pick = (last == 0);
      else pick = (pd > 0);
      order.push_back(pick);
      if (pick) pd--;
      else pi--;
      last = pick ? 1 : 0;
    end
    model_last = last;
    foreach (order[n]) begin
      if (order[n] && d_st) begin
        eb.push_back('{1'b1, da, wd, ws});
        el.push_back('0);
      end else begin
        logic [31:0]   base;
        logic [LB-1:0] line;
        base = (order[n] ? da : ia) & ~32'(LW * 4 - 1);
        for (int k = 0; k < LW; k++) begin
          eb.push_back('{1'b0, base + 32'(4 * k), 32'd0, 4'd0});
          line[k*32 +: 32] = mem_word(base + 32'(4 * k));
        end
        el.push_back(line);
      end
    end

    beats.delete();
    rdys.delete();
    @(posedge clk);
    #1;
    i_addr = ia; d_addr = da; d_for_store = d_st; d_wdata = wd; d_wstrb = ws;
    i_valid = use_i;
    d_valid = use_d;
    start = cyc;
    waited = 0;
    iseen = 0;
    dseen = 0;
    while ((iseen < ni || dseen < nd) && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
      iseen = 0;
      dseen = 0;
      foreach (rdys[n]) if (rdys[n].is_d) dseen++; else iseen++;
      i_valid = (iseen < ni);
      d_valid = (dseen < nd);
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    if (waited >= 300) check({tag, " timeout"}, LB'(waited), LB'(0));
    repeat (3) @(posedge clk);
    #1;

    check({tag, " ready count"}, LB'(rdys.size()), LB'(order.size()));
    for (int n = 0; n < rdys.size() && n < order.size(); n++) begin
      check({tag, " service order"}, LB'(rdys[n].is_d), LB'(order[n]));
      if (!(order[n] && d_st)) check({tag, " line data"}, rdys[n].rdata, el[n]);
    end
    if (exp_first >= 0 && rdys.size() > 0) check({tag, " first"}, LB'(rdys[0].is_d), LB'(exp_first));
    if (exp_lat >= 0 && rdys.size() > 0) check({tag, " latency"}, LB'(rdys[0].c - start), LB'(exp_lat));
    check({tag, " beat count"}, LB'(beats.size()), LB'(eb.size()));
    for (int n = 0; n < beats.size() && n < eb.size(); n++) begin
      check({tag, " beat"}, LB'(beats[n]), LB'(eb[n]));
    end
  endtask

  typedef struct {
    bit          ui, ud, st;
    int          dc;
    logic [31:0] ia, da, wd;
    logic [3:0]  ws;
    int          lat;    // cycles from request cycle to ready, -1 = unchecked
    int          first;  // 0 = I, 1 = D
  } vec_t;

  vec_t vt[6];

  initial begin
    // Latency counts the request cycle as cycle 1, so ready lands LW+1 / 2
    // clock edges after the request is raised.
    vt[0] = '{1, 1, 0, 1, 32'h1000, 32'h3014, 32'h0, 4'h0, -1, 1};
    vt[1] = '{1, 0, 0, 1, 32'h1004, 32'h0, 32'h0, 4'h0, LW + 1, 0};
    vt[2] = '{1, 1, 0, 2, 32'h5000, 32'h4008, 32'h0, 4'h0, -1, 1};
    vt[3] = '{0, 1, 1, 1, 32'h0, 32'h2008, 32'hDEAD_BEEF, 4'hF, 2, 1};
    vt[4] = '{1, 1, 1, 1, 32'h1040, 32'h2100, 32'h1234_5678, 4'h3, -1, 0};
    vt[5] = '{0, 1, 0, 1, 32'h0, 32'h6FFC, 32'h0, 4'h0, LW + 1, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset m_valid", LB'(m_valid), '0);
    check("reset readies", LB'({i_ready, d_ready}), '0);
    check("reset line", i_rdata, '0);
    rst = 1'b1;
    model_last = 0;

    foreach (vt[n]) begin
      do_txn($sformatf("vec%0d", n), vt[n].ui, vt[n].ud, vt[n].st, vt[n].dc, vt[n].ia,
             vt[n].da, vt[n].wd, vt[n].ws, vt[n].lat, vt[n].first);
    end

    // Three-cycle stall on beat 2.
    rmode = 2;
    stall_cnt = 0;
    do_txn("stall", 1, 0, 0, 1, 32'h1100, 32'h0, 32'h0, 4'h0, -1, 0);
    check("stall happened", LB'(stall_cnt), LB'(3));
    rmode = 0;

    // Reset during beat 1 of an I line read.
    dmode = 1'b1;
    rdys.delete();
    @(posedge clk);
    #1;
    i_addr = 32'h1004;
    i_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre-reset beat1", LB'({m_valid, m_addr}), LB'({1'b1, 32'h1004}));
    rst = 1'b0;
    #1;
    check("async reset outputs", LB'({m_valid, m_we, m_addr, m_wdata, m_wstrb, i_ready, d_ready}), '0);
    check("async reset line", i_rdata, '0);
    i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no ready after abort", LB'(rdys.size()), '0);
    model_last = 0;
    do_txn("post-reset", 1, 0, 0, 1, 32'h1004, 32'h0, 32'h0, 4'h0, LW + 1, 0);

    // Random traffic under a random memory handshake.
    rmode = 1;
    for (int it = 0; it < 30; it++) begin
      int sel;
      sel = $urandom_range(0, 2);
      do_txn($sformatf("rand%0d", it), sel != 1, sel != 0, 1'($urandom_range(0, 1)),
             $urandom_range(1, 2), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
             $urandom, 4'($urandom_range(0, 15)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
